// File: rtl/ethernet_tx_scheduler.sv
// ethernet_tx_scheduler
// Round-robin owner selection for the shared Ethernet TX path. It latches
// the winner's frame parameters, optionally reseeds the payload LFSR, runs
// the start/busy handshake, and enforces a quiet period between frames.
module ethernet_tx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int SIZE_W        = 16,
    parameter int START_TIMEOUT = 64,
    parameter int HOLDOFF       = 8
) (
    input  logic                      i_main_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*SIZE_W-1:0] i_req_payload_size,
    input  logic [NUM_REQ-1:0]        i_req_use_lfsr,
    input  logic [NUM_REQ-1:0]        i_req_seed_rst,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [NUM_REQ-1:0]        o_done,
    output logic [NUM_REQ-1:0]        o_error,
    output logic                      o_tx_start,
    output logic [SIZE_W-1:0]         o_tx_payload_size,
    output logic                      o_tx_use_lfsr,
    output logic                      o_lfsr_seed_rst,
    input  logic                      i_tx_fsm_busy,
    output logic                      o_busy,
    output logic [15:0]               o_frame_count
);

    localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX   = (START_TIMEOUT > HOLDOFF) ? START_TIMEOUT : HOLDOFF;
    localparam int CNT_W     = $clog2(CNT_MAX + 1) + 1;
    // HOLDOFF of zero still spends one cycle in HOLD
    localparam int HOLD_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_WAIT_IDLE,
        S_START,
        S_BUSY,
        S_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    w_winner;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic [PTR_W-1:0]    w_idx;
    logic                w_found;
    logic [SIZE_W-1:0]   w_win_size;
    logic [NUM_REQ-1:0]  w_win_onehot;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_zerr;
    logic [SIZE_W-1:0]   r_size;
    logic                r_lfsr;
    logic [15:0]         r_frame_count;
    logic                w_arb;
    logic                w_zero;
    logic                w_done_ev;
    logic                w_tmo_ev;

    // Search for the first pending request starting at the pointer, with wrap-around
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_win_size   = i_req_payload_size[int'(w_winner)*SIZE_W +: SIZE_W];
    assign w_win_onehot = NUM_REQ'(1) << w_winner;
    assign w_ptr_nxt    = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + PTR_W'(1);

    // Next-state and single-cycle event decode
    always_comb begin
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        w_zero      = 1'b0;
        w_done_ev   = 1'b0;
        w_tmo_ev    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable && w_found) begin
                    w_arb = 1'b1;
                    if (w_win_size == '0) begin
                        // Empty frame: reject without touching the TX path
                        w_zero = 1'b1;
                    end else if (i_req_seed_rst[w_winner]) begin
                        w_state_nxt = S_SEED;
                    end else begin
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_SEED: begin
                w_state_nxt = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (!i_tx_fsm_busy) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (i_tx_fsm_busy) begin
                    w_state_nxt = S_BUSY;
                end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    w_tmo_ev    = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_BUSY: begin
                if (!i_tx_fsm_busy) begin
                    w_done_ev   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt >= CNT_W'(HOLD_LAST)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_main_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-state cycle counter, cleared on every state change
    always_ff @(posedge i_main_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if ((r_state != w_state_nxt) || (r_state == S_IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Grant, latched frame parameters, pointer and frame counter
    always_ff @(posedge i_main_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr         <= '0;
            r_grant       <= '0;
            r_zerr        <= '0;
            r_size        <= '0;
            r_lfsr        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_zerr <= '0;
            if (w_arb) begin
                r_ptr <= w_ptr_nxt;
                if (w_zero) begin
                    r_zerr <= w_win_onehot;
                end else begin
                    r_grant <= w_win_onehot;
                    r_size  <= w_win_size;
                    r_lfsr  <= i_req_use_lfsr[w_winner];
                end
            end
            // Ownership ends on the edge after the done/error pulse
            if (w_done_ev || w_tmo_ev) begin
                r_grant <= '0;
            end
            if (w_done_ev) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // Control strobes decode straight from state so reset drops them instantly
    assign o_tx_start        = (r_state == S_START);
    assign o_lfsr_seed_rst   = (r_state == S_SEED);
    assign o_busy            = (r_state != S_IDLE);
    assign o_grant           = r_grant;
    assign o_done            = w_done_ev ? r_grant : '0;
    assign o_error           = r_zerr | (w_tmo_ev ? r_grant : '0);
    assign o_tx_payload_size = r_size;
    assign o_tx_use_lfsr     = r_lfsr;
    assign o_frame_count     = r_frame_count;

endmodule
